// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller driving an external RAM with one-cycle read latency.
// Optional sticky overflow/underflow flags are built when FIFO_CTRL_ERR_FLAGS_EN is defined.
module fifo_ctrl #(
  parameter int unsigned DEEP   = 8,
  parameter int unsigned AF_LVL = 2**DEEP - 2,
  parameter int unsigned AE_LVL = 2
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            w_req,
  input  logic            r_req,
  output logic            w_en,
  output logic            r_en,
  output logic [DEEP-1:0] address_w,
  output logic [DEEP-1:0] address_r,
  output logic            data_valid,
  output logic            full,
  output logic            empty,
  output logic            almost_full,
  output logic            almost_empty,
  output logic [DEEP:0]   count,
  output logic            overflow,
  output logic            underflow
);

  localparam logic [DEEP:0] ONE    = {{DEEP{1'b0}}, 1'b1};
  localparam logic [DEEP:0] AF_CNT = AF_LVL[DEEP:0];
  localparam logic [DEEP:0] AE_CNT = AE_LVL[DEEP:0];

  logic [DEEP:0] wp_q, wp_d;
  logic [DEEP:0] rp_q, rp_d;
  logic [DEEP:0] count_q, count_d;
  logic          data_valid_q, data_valid_d;

  // Flags come from registered pointers only; strobes are gated off during reset.
  always_comb begin
    empty = (wp_q == rp_q);
    full  = (wp_q[DEEP] != rp_q[DEEP]) && (wp_q[DEEP-1:0] == rp_q[DEEP-1:0]);
    w_en  = w_req & ~full & ~rst;
    r_en  = r_req & ~empty & ~rst;

    wp_d         = w_en ? wp_q + ONE : wp_q;
    rp_d         = r_en ? rp_q + ONE : rp_q;
    data_valid_d = r_en;

    count_d = count_q;
    case ({w_en, r_en})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      wp_q         <= '0;
      rp_q         <= '0;
      count_q      <= '0;
      data_valid_q <= 1'b0;
    end else begin
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      count_q      <= count_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign address_w    = wp_q[DEEP-1:0];
  assign address_r    = rp_q[DEEP-1:0];
  assign count        = count_q;
  assign data_valid   = data_valid_q;
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (w_req & full);
    underflow_d = underflow_q | (r_req & empty);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl (DEEP=2, AF_LVL=3, AE_LVL=1): vector table,
// corner-case sequences and random traffic checked against a queue-based occupancy model.
module tb_fifo_ctrl;

  localparam int DEEP = 2;
  localparam int CAP  = 4;

  logic            clk_in = 1'b0;
  logic            rst, w_req, r_req;
  logic            w_en, r_en, data_valid;
  logic [DEEP-1:0] address_w, address_r;
  logic            full, empty, almost_full, almost_empty;
  logic [DEEP:0]   count;
  logic            overflow, underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of RAM addresses holding live words.
  int m_q[$];
  int m_wr;
  bit m_dv, m_ov, m_uf;

  always #5 clk_in = ~clk_in;

  fifo_ctrl #(.DEEP(DEEP), .AF_LVL(3), .AE_LVL(1)) dut (
    .clk_in(clk_in), .rst(rst), .w_req(w_req), .r_req(r_req),
    .w_en(w_en), .r_en(r_en), .address_w(address_w), .address_r(address_r),
    .data_valid(data_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  typedef struct {
    bit w, r, rs;
    bit exp_wen, exp_ren;
    int exp_cnt;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Applies one cycle of stimulus, checks all outputs against the model, then advances.
  task automatic cycle(input bit w, input bit r, input bit rs, output bit we_s, output bit re_s);
    int cnt;
    int exp_ar;
    bit we, re;
    w_req = w; r_req = r; rst = rs;
    #1;
    cnt = m_q.size();
    we  = w && !rs && cnt < CAP;
    re  = r && !rs && cnt > 0;
    if (cnt > 0) exp_ar = m_q[0];
    else         exp_ar = m_wr % CAP;
    chk("w_en", w_en, we);
    chk("r_en", r_en, re);
    chk("count", count, cnt);
    chk("empty", empty, cnt == 0);
    chk("full", full, cnt == CAP);
    chk("almost_full", almost_full, cnt >= 3);
    chk("almost_empty", almost_empty, cnt <= 1);
    chk("address_w", address_w, m_wr % CAP);
    chk("address_r", address_r, exp_ar);
    chk("data_valid", data_valid, m_dv);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    chk("overflow", overflow, m_ov);
    chk("underflow", underflow, m_uf);
`else
    chk("overflow", overflow, 0);
    chk("underflow", underflow, 0);
`endif
    we_s = w_en;
    re_s = r_en;
    if (rs) begin
      m_q.delete();
      m_wr = 0; m_dv = 0; m_ov = 0; m_uf = 0;
    end else begin
      if (w && cnt == CAP) m_ov = 1;
      if (r && cnt == 0)   m_uf = 1;
      if (re) void'(m_q.pop_front());
      if (we) begin
        m_q.push_back(m_wr % CAP);
        m_wr++;
      end
      m_dv = re;
    end
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[$];
    bit we, re;

    tbl.push_back('{1, 1, 1, 0, 0, 0});  // reset forces strobes low
    tbl.push_back('{1, 0, 0, 1, 0, 1});
    tbl.push_back('{1, 0, 0, 1, 0, 2});
    tbl.push_back('{1, 0, 0, 1, 0, 3});
    tbl.push_back('{1, 0, 0, 1, 0, 4});
    tbl.push_back('{1, 0, 0, 0, 0, 4});  // write into full refused
    tbl.push_back('{1, 1, 0, 0, 1, 3});  // full: read wins
    tbl.push_back('{0, 0, 0, 0, 0, 3});
    tbl.push_back('{0, 1, 0, 0, 1, 2});
    tbl.push_back('{0, 1, 0, 0, 1, 1});
    tbl.push_back('{0, 1, 0, 0, 1, 0});
    tbl.push_back('{1, 1, 0, 1, 0, 1});  // empty: write wins
    tbl.push_back('{0, 0, 1, 0, 0, 0});

    rst = 1'b1; w_req = 1'b0; r_req = 1'b0;
    m_q.delete(); m_wr = 0; m_dv = 0; m_ov = 0; m_uf = 0;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].w, tbl[i].r, tbl[i].rs, we, re);
      chk($sformatf("vec%0d_w_en", i), we, tbl[i].exp_wen);
      chk($sformatf("vec%0d_r_en", i), re, tbl[i].exp_ren);
      chk($sformatf("vec%0d_count", i), count, tbl[i].exp_cnt);
    end

    // Steady state at count=2 with simultaneous traffic; addresses wrap.
    cycle(0, 0, 1, we, re);
    cycle(1, 0, 0, we, re);
    cycle(1, 0, 0, we, re);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, 0, we, re);
      chk("both_w_en", we, 1);
      chk("both_r_en", re, 1);
      chk("both_count", count, 2);
      chk("both_no_full", full, 0);
      chk("both_no_empty", empty, 0);
    end
    chk("wrap_address_w", address_w, 0);
    chk("wrap_address_r", address_r, 2);

    // Reset with a read in flight at count=3.
    cycle(0, 0, 1, we, re);
    cycle(1, 0, 0, we, re);
    cycle(1, 0, 0, we, re);
    cycle(1, 0, 0, we, re);
    cycle(1, 1, 0, we, re);
    chk("inflight_dv", data_valid, 1);
    cycle(0, 1, 1, we, re);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_dv", data_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);

    // Random traffic with phase-dependent write/read bias and rare resets.
    for (int i = 0; i < 600; i++) begin
      int wp, rp;
      wp = ((i / 50) % 2 == 0) ? 70 : 30;
      rp = 100 - wp;
      cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
            $urandom_range(0, 63) == 0, we, re);
    end

    // Error flags hold until reset.
    cycle(0, 0, 1, we, re);
    cycle(0, 1, 0, we, re);
    cycle(0, 0, 0, we, re);
    cycle(0, 0, 0, we, re);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
